// File: rtl/imm_ext_pipe.sv
// Pipelined immediate-extension unit: four extension modes and a sideband tag,
// with a valid/ready handshake and a one-entry skid buffer behind the output register.
module imm_ext_pipe #(
  parameter int IN_W     = 16,
  parameter int OUT_W    = 32,
  parameter int TAG_W    = 5,
  parameter int BR_SHIFT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_imm,
  output logic [TAG_W-1:0] out_tag
);

  localparam int PAD_W = OUT_W - IN_W;

  // Extension is applied on accept, so only finished results are stored.
  function automatic logic [OUT_W-1:0] extend(input logic [IN_W-1:0] imm,
                                              input logic [1:0] mode);
    logic [OUT_W-1:0] sext;
    sext = {{PAD_W{imm[IN_W-1]}}, imm};
    case (mode)
      2'b00:   extend = sext;
      2'b01:   extend = {{PAD_W{1'b0}}, imm};
      2'b10:   extend = {imm, {PAD_W{1'b0}}};
      2'b11:   extend = sext << BR_SHIFT;
      default: extend = sext;
    endcase
  endfunction

  logic             or_valid_r;
  logic [OUT_W-1:0] or_imm_r;
  logic [TAG_W-1:0] or_tag_r;
  logic             sk_valid_r;
  logic [OUT_W-1:0] sk_imm_r;
  logic [TAG_W-1:0] sk_tag_r;

  logic             accept_s;
  logic             or_free_s;
  logic [OUT_W-1:0] ext_s;

  // in_ready depends only on registered skid state and reset, never on out_ready.
  assign in_ready  = !sk_valid_r && !rst;
  assign accept_s  = in_valid && in_ready;
  assign or_free_s = !or_valid_r || out_ready;
  assign ext_s     = extend(in_imm, in_mode);

  assign out_valid = or_valid_r;
  assign out_imm   = or_imm_r;
  assign out_tag   = or_tag_r;

  // Output register and skid buffer update; the skid entry always drains first to keep order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      or_valid_r <= 1'b0;
      or_imm_r   <= {OUT_W{1'b0}};
      or_tag_r   <= {TAG_W{1'b0}};
      sk_valid_r <= 1'b0;
      sk_imm_r   <= {OUT_W{1'b0}};
      sk_tag_r   <= {TAG_W{1'b0}};
    end else if (or_free_s) begin
      if (sk_valid_r) begin
        or_valid_r <= 1'b1;
        or_imm_r   <= sk_imm_r;
        or_tag_r   <= sk_tag_r;
        sk_valid_r <= accept_s;
        if (accept_s) begin
          sk_imm_r <= ext_s;
          sk_tag_r <= in_tag;
        end
      end else begin
        or_valid_r <= accept_s;
        if (accept_s) begin
          or_imm_r <= ext_s;
          or_tag_r <= in_tag;
        end
      end
    end else if (accept_s) begin
      sk_valid_r <= 1'b1;
      sk_imm_r   <= ext_s;
      sk_tag_r   <= in_tag;
    end
  end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Scoreboard bench for imm_ext_pipe: the driver pushes expected results on accept,
// an independent monitor pops and compares whenever an output item is consumed.
module tb_imm_ext_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_imm;
  logic [1:0]  in_mode;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_imm;
  logic [4:0]  out_tag;

  typedef struct packed {
    logic [31:0] imm;
    logic [4:0]  tag;
  } item_t;

  item_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    rdy_mode = 0;   // 0: always ready, 1: never ready, 2: random
  logic  rdy_rand = 1'b1;

  imm_ext_pipe #(.IN_W(16), .OUT_W(32), .TAG_W(5), .BR_SHIFT(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm),
    .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_imm(out_imm), .out_tag(out_tag)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign out_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'b0 : rdy_rand;

  always @(posedge clk) begin
    #1 rdy_rand = 1'($urandom_range(0, 1));
  end

  // Reference: extension rules evaluated with signed integer arithmetic.
  function automatic logic [31:0] model(input logic [15:0] imm, input logic [1:0] mode);
    longint s;
    longint u;
    u = longint'(imm);
    s = (u >= 32768) ? u - 65536 : u;
    case (mode)
      2'd0:    return 32'(s);
      2'd1:    return 32'(u);
      2'd2:    return 32'(u * 65536);
      default: return 32'(s * 4);
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [15:0] imm, input logic [1:0] mode, input logic [4:0] tag,
                      input logic [31:0] expv, output int waits);
    bit ok;
    item_t it;
    in_valid = 1'b1;
    in_imm   = imm;
    in_mode  = mode;
    in_tag   = tag;
    waits    = 0;
    ok       = 1'b0;
    while (!ok && waits <= 60) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      else begin
        waits++;
        @(posedge clk);
        #1;
      end
    end
    if (ok) begin
      it.imm = expv;
      it.tag = tag;
      exp_q.push_back(it);
      @(posedge clk);
      #1;
    end else begin
      checks++;
      errors++;
      $display("FAIL accept_timeout tag=%0d actual=not_accepted required=accepted", tag);
    end
    in_valid = 1'b0;
    in_imm   = 16'($urandom);
    in_mode  = 2'($urandom);
    in_tag   = 5'($urandom);
  endtask

  task automatic check_next_cycle_valid(input string name);
    @(negedge clk);
    check(name, {31'd0, out_valid}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares consumed items against the scoreboard and checks stall stability.
  logic        stall_v = 1'b0;
  logic [31:0] stall_imm;
  logic [4:0]  stall_tag;
  always @(negedge clk) begin
    if (rst) begin
      stall_v = 1'b0;
    end else begin
      if (stall_v) begin
        check("stall_imm_stable", out_imm, stall_imm);
        check("stall_tag_stable", {27'd0, out_tag}, {27'd0, stall_tag});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_item actual=0x%08h/tag%0d required=none", out_imm, out_tag);
        end else begin
          item_t e;
          e = exp_q.pop_front();
          check("out_imm", out_imm, e.imm);
          check("out_tag", {27'd0, out_tag}, {27'd0, e.tag});
        end
      end
      stall_v   = out_valid && !out_ready;
      stall_imm = out_imm;
      stall_tag = out_tag;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int w;
    int total_w;
    logic [15:0] r_imm;
    logic [1:0]  r_mode;
    rst = 1'b1;
    in_valid = 1'b0;
    in_imm = 16'd0;
    in_mode = 2'd0;
    in_tag = 5'd0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_imm", out_imm, 32'd0);
    check("rst_out_tag", {27'd0, out_tag}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    #2 rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Directed extension cases with out_ready=1
    send(16'h8001, 2'd0, 5'd3, 32'hFFFF8001, w);
    check_next_cycle_valid("latency_m00");
    send(16'h7FFF, 2'd0, 5'd4, 32'h00007FFF, w);
    check_next_cycle_valid("latency_m00b");
    send(16'h8001, 2'd1, 5'd5, 32'h00008001, w);
    check_next_cycle_valid("latency_m01");
    send(16'h1234, 2'd2, 5'd6, 32'h12340000, w);
    check_next_cycle_valid("latency_m10");
    send(16'hFFFF, 2'd3, 5'd7, 32'hFFFFFFFC, w);
    check_next_cycle_valid("latency_m11a");
    send(16'h4000, 2'd3, 5'd8, 32'h00010000, w);
    check_next_cycle_valid("latency_m11b");
    send(16'h8000, 2'd3, 5'd9, 32'hFFFE0000, w);
    check_next_cycle_valid("latency_m11c");

    // Back-pressure: two accepted, third held off until out_ready rises
    rdy_mode = 1;
    send(16'h0011, 2'd0, 5'd1, 32'h00000011, w);
    send(16'h0022, 2'd0, 5'd2, 32'h00000022, w);
    @(negedge clk);
    check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    fork
      send(16'hF033, 2'd0, 5'd3, 32'hFFFFF033, w);
      begin
        @(negedge clk);
        check("bp_held_off", {31'd0, in_ready}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rdy_mode = 0;
      end
    join

    // Full-rate burst: no wait cycles while out_ready stays high
    total_w = 0;
    for (int i = 0; i < 10; i++) begin
      r_imm  = 16'($urandom);
      r_mode = 2'($urandom);
      send(r_imm, r_mode, 5'(i), model(r_imm, r_mode), w);
      total_w += w;
    end
    check("full_rate_waits", 32'(total_w), 32'd0);

    // Random streaming with 50% out_ready
    rdy_mode = 2;
    for (int i = 0; i < 100; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      r_imm  = 16'($urandom);
      r_mode = 2'($urandom);
      send(r_imm, r_mode, 5'($urandom), model(r_imm, r_mode), w);
    end
    rdy_mode = 0;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("stream_drained", 32'(exp_q.size()), 32'd0);

    // Reset mid-operation with both entries full
    rdy_mode = 1;
    send(16'hAAAA, 2'd1, 5'd10, 32'h0000AAAA, w);
    send(16'hBBBB, 2'd1, 5'd11, 32'h0000BBBB, w);
    #2 rst = 1'b1;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    rdy_mode = 0;
    @(negedge clk);
    check("postrst_in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      check("postrst_no_stale", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    send(16'h8765, 2'd0, 5'd12, 32'hFFFF8765, w);
    check_next_cycle_valid("postrst_latency");
    repeat (2) @(posedge clk);
    #1;
    check("final_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_ext_pipe.md
Name: imm_ext_pipe

Overview:
- Parametrised, pipelined immediate-extension unit for the decode stage of the pipelined processor. Successor to the fixed 16-to-32 sign extender.
- Supports four extension modes, configurable widths, and a sideband tag (e.g. destination register or PC index) that travels with each immediate.
- Uses a valid/ready handshake on both sides with a one-entry skid buffer, so full throughput is kept under back-pressure.

Parameters:
- IN_W, 16: immediate input width; must be ≥1.
- OUT_W, 32: extended output width; must be > IN_W.
- TAG_W, 5: sideband tag width; must be ≥1.
- BR_SHIFT, 2: left shift applied in branch mode; must be < OUT_W.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input item present.
- in_ready  out  1  unit can accept an input item this cycle.
- in_imm  in  IN_W  raw immediate.
- in_mode  in  2  00 sign-extend, 01 zero-extend, 10 upper, 11 branch offset.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  output item present.
- out_ready  in  1  consumer accepts the output item this cycle.
- out_imm  out  OUT_W  extended immediate.
- out_tag  out  TAG_W  tag of the item on out_imm.

Behaviour:
- Reset is asynchronous and active-high. While rst=1:
  - out_valid=0, out_imm=0, out_tag=0.
  - Skid buffer is empty (valid=0, data=0).
  - in_ready=0.
  - Any item in flight is discarded and no handshake completes.
- After rst deasserts, in_ready=1 in the first cycle.
- Arithmetic is applied when an item is accepted, and the result is what gets stored:
  - Mode 00: replicate in_imm[IN_W-1] into bits OUT_W-1..IN_W.
  - Mode 01: zero-fill bits OUT_W-1..IN_W.
  - Mode 10: in_imm occupies bits OUT_W-1..OUT_W-IN_W; the low bits are zero.
  - Mode 11: sign-extend to OUT_W, shift left by BR_SHIFT, keep the low OUT_W bits (upper bits are discarded).
- Handshake rules:
  - An input is accepted when in_valid && in_ready at a clock edge.
  - An output is consumed when out_valid && out_ready at a clock edge.
  - in_imm, in_mode and in_tag are don't-care when in_valid=0.
  - out_imm and out_tag hold stable while out_valid=1 && out_ready=0.
- Latency and throughput:
  - An item accepted at edge N appears with out_valid=1 after edge N, provided the output register is free or is being consumed at edge N.
  - Sustained throughput is one item per cycle when out_ready stays high.
- Storage is two entries, an output register (OR) and a skid register (SK). At each edge:
  - If OR is empty or being consumed: OR loads SK if SK is valid, else OR loads the accepted input. SK is cleared when its contents move to OR.
  - If SK moves to OR and an input is accepted in the same edge, the input goes into SK.
  - If OR is full and not consumed, an accepted input goes into SK.
  - in_ready = !SK.valid && !rst. It is a registered-state function with no combinational path from out_ready.
- Ordering: items leave in strict acceptance order. No item is dropped or duplicated.
- Boundary conditions:
  - Both entries full: in_ready=0. in_valid is ignored until OR is consumed; at that edge SK moves to OR and in_ready returns to 1 in the next cycle.
  - Simultaneous accept and consume with only OR full: the new item replaces OR and SK stays empty.
  - in_mode is sampled only on accept; changing it while an item is held has no effect on that item.
  - Reset mid-transfer: the next edge after rst deasserts behaves as a fresh start.
- All state is held in flip-flops. No latches and no combinational path from in_* to out_*.

Test Plan (IN_W=16, OUT_W=32, TAG_W=5, BR_SHIFT=2):
- Mode 00, out_ready=1:
  - imm 0x8001, tag 3 -> out_imm 0xFFFF8001, tag 3, one cycle after accept.
  - imm 0x7FFF -> 0x00007FFF.
- Mode 01: imm 0x8001 -> 0x00008001. Mode 10: imm 0x1234 -> 0x12340000.
- Mode 11: imm 0xFFFF -> 0xFFFFFFFC. imm 0x4000 -> 0x00010000. imm 0x8000 -> 0xFFFE0000.
- Back-pressure:
  - Hold out_ready=0 and present tags 1, 2, 3 back-to-back in mode 00.
  - Required: tags 1 and 2 are accepted, in_ready=0 after the second accept, and tag 3 is held off.
  - Then raise out_ready: outputs appear in order 1, 2, 3 with no loss. OR stays stable while stalled.
- Streaming: 100 random items with random out_ready (50%). Scoreboard shows every item delivered in order with correct extension, and full rate when out_ready=1.
- Reset mid-operation:
  - Fill both entries, then assert rst asynchronously between edges.
  - Required: out_valid=0 and in_ready=0 immediately; after release, no stale items are emitted and a new item passes normally.
